spi_multi_sched: RTL and testbench

- Transaction scheduler that sits in the sys_clk domain in front of the multi-slave SPI interface (if_spi_multi).
- Shares the single SPI master between N_SLAVES requesters with round-robin arbitration.
- For each granted request it pushes one command frame of BYTES_PER_FRAME bytes into the master FIFO, targeted at the requester's chip-select.
- It then waits for the matching response bytes in the slave FIFO, drains them, and returns them to the requester with a done pulse.

---
 rtl/spi_multi_sched.sv | 155 +++++++++++++++
 tb/tb_spi_multi_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_multi_sched.sv
// spi_multi_sched: round-robin SPI transaction scheduler; define SPI_SCHED_TIMEOUT_EN for the WAIT_RX timeout and FIFO flush
module spi_multi_sched #(
  parameter int N_SLAVES        = 3,
  parameter int BYTES_PER_FRAME = 2,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic                                  sys_clk,
  input  logic                                  rst,
  input  logic [N_SLAVES-1:0]                   req_bus,
  input  logic [8*BYTES_PER_FRAME*N_SLAVES-1:0] wdata_bus,
  output logic [N_SLAVES-1:0]                   ack_bus,
  output logic [N_SLAVES-1:0]                   done_bus,
  output logic [8*BYTES_PER_FRAME-1:0]          rdata,
  output logic                                  err,
  output logic                                  busy,
  output logic [7:0]                            m_din,
  output logic [N_SLAVES-1:0]                   m_wrreq_bus,
  output logic [N_SLAVES-1:0]                   s_rdreq_bus,
  input  logic [8*N_SLAVES-1:0]                 s_dout_bus,
  input  logic [N_SLAVES-1:0]                   have_msg_bus,
  input  logic [8*N_SLAVES-1:0]                 len_bus
);
  localparam int W  = 8*BYTES_PER_FRAME;
  localparam int IW = N_SLAVES > 1 ? $clog2(N_SLAVES) : 1;
  localparam int CW = $clog2(BYTES_PER_FRAME + 2) + 1;
  localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WAIT_RX = 3'd2, READ = 3'd3, DONE = 3'd4;
`ifdef SPI_SCHED_TIMEOUT_EN
  localparam logic [2:0]  FLUSH  = 3'd5;
  localparam logic [15:0] T_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tcnt;
`endif
  if (N_SLAVES < 1 || N_SLAVES > 8 || BYTES_PER_FRAME < 1 || BYTES_PER_FRAME > 8 ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_cfg
    $error("spi_multi_sched: parameter out of range");
  end
  logic [2:0]          state;
  logic [IW-1:0]       last, sel, nxt, cand;
  logic [CW-1:0]       cnt;
  logic [W-1:0]        shreg, rx_sh;
  logic [N_SLAVES-1:0] sel_oh, nxt_oh;
  logic                cap, rx_ready;
  logic [W-1:0]        wd [N_SLAVES];
  logic [7:0]          sd [N_SLAVES];
  logic [7:0]          ln [N_SLAVES];
  for (genvar i = 0; i < N_SLAVES; i++) begin : g_sl
    assign wd[i] = wdata_bus[W*i +: W];
    assign sd[i] = s_dout_bus[8*i +: 8];
    assign ln[i] = len_bus[8*i +: 8];
  end
  assign sel_oh   = N_SLAVES'(1) << sel;
  assign nxt_oh   = N_SLAVES'(1) << nxt;
  assign rx_ready = have_msg_bus[sel] && ln[sel] >= 8'(BYTES_PER_FRAME);
  assign busy     = state != IDLE;
`ifndef SPI_SCHED_TIMEOUT_EN
  assign err = 1'b0;
`endif
  // Round-robin pick: scan downward so the nearest requester after last wins.
  always_comb begin
    nxt  = last;
    cand = '0;
    for (int d = N_SLAVES; d >= 1; d--) begin
      cand = IW'((int'(last) + d) % N_SLAVES);
      if (req_bus[cand]) nxt = cand;
    end
  end
  // Transaction FSM: grant, push command bytes, wait for response, drain and report.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      last        <= IW'(N_SLAVES - 1);
      sel         <= '0;
      cnt         <= '0;
      shreg       <= '0;
      rx_sh       <= '0;
      cap         <= 1'b0;
      ack_bus     <= '0;
      done_bus    <= '0;
      rdata       <= '0;
      m_din       <= '0;
      m_wrreq_bus <= '0;
      s_rdreq_bus <= '0;
`ifdef SPI_SCHED_TIMEOUT_EN
      err         <= 1'b0;
      tcnt        <= '0;
`endif
    end else begin
      ack_bus     <= '0;
      done_bus    <= '0;
      m_wrreq_bus <= '0;
      s_rdreq_bus <= '0;
      m_din       <= '0;
      cap         <= 1'b0;
      case (state)
        IDLE: if (|req_bus) begin
          sel     <= nxt;
          last    <= nxt;
          ack_bus <= nxt_oh;
          shreg   <= wd[nxt];
          cnt     <= '0;
          state   <= LOAD;
        end
        LOAD: begin
          m_wrreq_bus <= sel_oh;
          m_din       <= shreg[W-1 -: 8];
          shreg       <= shreg << 8;
          cnt         <= cnt + 1'b1;
`ifdef SPI_SCHED_TIMEOUT_EN
          tcnt        <= '0;
`endif
          if (cnt == CW'(BYTES_PER_FRAME - 1)) begin
            cnt   <= '0;
            state <= WAIT_RX;
          end
        end
        WAIT_RX: begin
`ifdef SPI_SCHED_TIMEOUT_EN
          tcnt <= tcnt + 1'b1;
          if (!rx_ready && tcnt == T_LAST) state <= FLUSH;
`endif
          if (rx_ready) begin
            cnt   <= '0;
            state <= READ;
          end
        end
        READ: begin
          s_rdreq_bus <= cnt < CW'(BYTES_PER_FRAME) ? sel_oh : '0;
          cap         <= |s_rdreq_bus;
          cnt         <= cnt + 1'b1;
          if (cap) rx_sh <= W'({rx_sh, sd[sel]});
          if (cnt == CW'(BYTES_PER_FRAME + 1)) begin
            rdata    <= W'({rx_sh, sd[sel]});
            done_bus <= sel_oh;
            state    <= DONE;
`ifdef SPI_SCHED_TIMEOUT_EN
            err      <= 1'b0;
`endif
          end
        end
`ifdef SPI_SCHED_TIMEOUT_EN
        FLUSH: begin
          s_rdreq_bus <= have_msg_bus[sel] && !(|s_rdreq_bus) ? sel_oh : '0;
          if (!have_msg_bus[sel] && !(|s_rdreq_bus)) begin
            rdata    <= '0;
            err      <= 1'b1;
            done_bus <= sel_oh;
            state    <= DONE;
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_multi_sched.sv
// tb_spi_multi_sched: randomized self-checking bench for spi_multi_sched with slave FIFO model
module tb_spi_multi_sched;
  localparam int N = 3;
  localparam int B = 2;
  localparam int W = 8*B;
`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int TO = 100;
`else
  localparam int TO = 65535;
`endif
  logic           sys_clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_bus = '0;
  logic [W*N-1:0] wdata_bus;
  logic [N-1:0]   ack_bus, done_bus, m_wrreq_bus, s_rdreq_bus, have_msg_bus;
  logic [W-1:0]   rdata;
  logic           err, busy;
  logic [7:0]     m_din;
  logic [8*N-1:0] s_dout_bus, len_bus;
  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  spi_multi_sched #(.N_SLAVES(N), .BYTES_PER_FRAME(B), .TIMEOUT_CYCLES(TO)) dut (
    .sys_clk(sys_clk), .rst(rst), .req_bus(req_bus), .wdata_bus(wdata_bus),
    .ack_bus(ack_bus), .done_bus(done_bus), .rdata(rdata), .err(err), .busy(busy),
    .m_din(m_din), .m_wrreq_bus(m_wrreq_bus), .s_rdreq_bus(s_rdreq_bus),
    .s_dout_bus(s_dout_bus), .have_msg_bus(have_msg_bus), .len_bus(len_bus)
  );

  logic [W-1:0] wd [N];
  logic [W-1:0] resp [N];
  logic [7:0]   fifo [N][$];
  logic [7:0]   dout_r [N];
  logic [7:0]   len_r [N];
  for (genvar g = 0; g < N; g++) begin : g_f
    assign wdata_bus[W*g +: W]  = wd[g];
    assign s_dout_bus[8*g +: 8] = dout_r[g];
    assign len_bus[8*g +: 8]    = len_r[g];
    assign have_msg_bus[g]      = len_r[g] != 0;
  end

  // Normal-mode slave FIFO: data appears the cycle after rdreq.
  initial for (int i = 0; i < N; i++) begin dout_r[i] = '0; len_r[i] = '0; end
  always @(posedge sys_clk) begin
    for (int i = 0; i < N; i++) begin
      if (s_rdreq_bus[i] && fifo[i].size() > 0) dout_r[i] <= fifo[i].pop_front();
      len_r[i] <= 8'(fifo[i].size());
    end
  end

  int ack_q[$];
  int done_q[$];
  logic [W-1:0] drd_q[$];
  logic derr_q[$];
  int dcyc_q[$];
  int wr_s[$];
  logic [7:0] wr_b[$];
  int rd_cycles [N];
  int wr_cnt [N];
  int cyc = 0;
  bit auto_resp = 0;

  function automatic int oh_idx(input logic [N-1:0] v);
    return $countones(v) == 1 ? $clog2(v) : -1;
  endfunction

  task automatic clear_logs();
    ack_q.delete(); done_q.delete(); drd_q.delete(); derr_q.delete(); dcyc_q.delete();
    wr_s.delete(); wr_b.delete();
    for (int i = 0; i < N; i++) rd_cycles[i] = 0;
  endtask

  task automatic step();
    int s;
    @(negedge sys_clk);
    cyc++;
    if (rst) for (int i = 0; i < N; i++) wr_cnt[i] = 0;
    if (ack_bus != 0) ack_q.push_back(oh_idx(ack_bus));
    if (m_wrreq_bus != 0) begin
      s = oh_idx(m_wrreq_bus);
      wr_s.push_back(s);
      wr_b.push_back(m_din);
      if (s >= 0) begin
        wr_cnt[s]++;
        if (wr_cnt[s] == B) begin
          wr_cnt[s] = 0;
          if (auto_resp) for (int k = B-1; k >= 0; k--) fifo[s].push_back(8'(resp[s] >> (8*k)));
        end
      end
    end
    for (int i = 0; i < N; i++) if (s_rdreq_bus[i]) rd_cycles[i]++;
    if (done_bus != 0) begin
      s = oh_idx(done_bus);
      done_q.push_back(s); drd_q.push_back(rdata); derr_q.push_back(err); dcyc_q.push_back(cyc);
      if (s >= 0) req_bus = req_bus & ~(N'(1) << s);
    end
  endtask

  task automatic run_until_quiet(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (req_bus == 0 && !busy) begin ok = 1; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1; req_bus = '0;
    repeat (2) @(negedge sys_clk);
    for (int i = 0; i < N; i++) begin fifo[i].delete(); wr_cnt[i] = 0; end
    rst = 0;
    @(negedge sys_clk);
  endtask

  task automatic test_reset();
    rst = 1;
    req_bus = N'($urandom_range(1, (1 << N) - 1));
    for (int i = 0; i < N; i++) wd[i] = W'($urandom);
    repeat (3) @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({ack_bus, done_bus, m_wrreq_bus, s_rdreq_bus} !== '0) begin errors++;
      $display("FAIL reset_pulses got=%h exp=0", {ack_bus, done_bus, m_wrreq_bus, s_rdreq_bus}); end
    checks++; if ({rdata, err, m_din} !== '0) begin errors++;
      $display("FAIL reset_data got=%h exp=0", {rdata, err, m_din}); end
    req_bus = '0; rst = 0;
    repeat (2) @(negedge sys_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int last_m, n;
    int slot [N];
    int order[$];
    logic [N-1:0] mask;
    bit ok;
    do_reset();
    last_m = N-1;
    for (int r = 0; r < 10; r++) begin
      mask = r == 0 ? N'(7) : r == 1 ? N'(5) : N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin wd[i] = W'($urandom); resp[i] = W'($urandom); slot[i] = -1; end
      for (int s = 0; s < N; s++) if (((mask >> s) & 1) != 0) slot[(s - last_m - 1 + N) % N] = s;
      order.delete();
      for (int d = 0; d < N; d++) if (slot[d] >= 0) order.push_back(slot[d]);
      last_m = order[order.size()-1];
      n = order.size();
      clear_logs(); auto_resp = 1; req_bus = mask;
      run_until_quiet(60*N, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_timeout round=%0d got=busy exp=idle", r); end
      checks++; if (ack_q.size() != n || done_q.size() != n) begin errors++;
        $display("FAIL rr_count round=%0d got=%0d/%0d exp=%0d", r, ack_q.size(), done_q.size(), n); end
      checks++; if (wr_s.size() != B*n) begin errors++;
        $display("FAIL rr_wr_count round=%0d got=%0d exp=%0d", r, wr_s.size(), B*n); end
      for (int k = 0; k < n; k++) begin
        checks++; if ((k < ack_q.size() ? ack_q[k] : -2) != order[k]) begin errors++;
          $display("FAIL rr_grant round=%0d k=%0d got=%0d exp=%0d", r, k, k < ack_q.size() ? ack_q[k] : -2, order[k]); end
        checks++; if ((k < done_q.size() ? done_q[k] : -2) != order[k]) begin errors++;
          $display("FAIL rr_done round=%0d k=%0d got=%0d exp=%0d", r, k, k < done_q.size() ? done_q[k] : -2, order[k]); end
        checks++; if ((k < drd_q.size() ? drd_q[k] : 'x) !== resp[order[k]] || (k < derr_q.size() ? derr_q[k] : 1'bx) !== 1'b0) begin errors++;
          $display("FAIL rr_rdata round=%0d k=%0d got=%h exp=%h", r, k, k < drd_q.size() ? drd_q[k] : 'x, resp[order[k]]); end
        for (int j = 0; j < B; j++) begin
          checks++;
          if (B*k+j >= wr_s.size() || wr_s[B*k+j] != order[k] || wr_b[B*k+j] !== 8'(wd[order[k]] >> (8*(B-1-j)))) begin
            errors++;
            $display("FAIL rr_wbyte round=%0d k=%0d j=%0d got=%h exp=%h", r, k, j,
                     B*k+j < wr_b.size() ? wr_b[B*k+j] : 8'hxx, 8'(wd[order[k]] >> (8*(B-1-j))));
          end
        end
      end
      checks++; if (rd_cycles[0] + rd_cycles[1] + rd_cycles[2] != B*n) begin errors++;
        $display("FAIL rr_rdreq round=%0d got=%0d exp=%0d", r, rd_cycles[0] + rd_cycles[1] + rd_cycles[2], B*n); end
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_logs(); auto_resp = 0;
    wd[1] = 16'hA55A; req_bus = 3'b010;
    step();
    checks++; if (ack_bus !== 3'b010 || m_wrreq_bus !== 3'b000) begin errors++;
      $display("FAIL single_ack got=%b/%b exp=010/000", ack_bus, m_wrreq_bus); end
    step();
    checks++; if (ack_bus !== 3'b000 || m_wrreq_bus !== 3'b010 || m_din !== 8'hA5 || busy !== 1'b1) begin errors++;
      $display("FAIL single_byte0 got=%b/%b/%h/%b exp=000/010/a5/1", ack_bus, m_wrreq_bus, m_din, busy); end
    step();
    checks++; if (m_wrreq_bus !== 3'b010 || m_din !== 8'h5A) begin errors++;
      $display("FAIL single_byte1 got=%b/%h exp=010/5a", m_wrreq_bus, m_din); end
    fifo[1].push_back(8'h12); fifo[1].push_back(8'h34);
    run_until_quiet(50, ok);
    checks++; if (!ok || done_q.size() != 1) begin errors++; $display("FAIL single_done got=%0d exp=1", done_q.size()); end
    checks++; if (rd_cycles[1] != 2 || rd_cycles[0] + rd_cycles[2] != 0) begin errors++;
      $display("FAIL single_rdreq got=%0d exp=2", rd_cycles[1]); end
    checks++; if (done_q.size() != 1 || done_q[0] != 1 || drd_q[0] !== 16'h1234 || derr_q[0] !== 1'b0) begin errors++;
      $display("FAIL single_rdata got=%h exp=1234", done_q.size() > 0 ? drd_q[0] : 16'hxxxx); end
  endtask

  task automatic test_slow_len();
    bit ok;
    logic [7:0] b0, b1;
    clear_logs(); auto_resp = 0;
    wd[0] = W'($urandom); b0 = 8'($urandom); b1 = 8'($urandom);
    req_bus = 3'b001;
    ok = 0;
    for (int i = 0; i < 20; i++) begin step(); if (wr_s.size() == B) begin ok = 1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL slow_load got=%0d exp=%0d", wr_s.size(), B); end
    fifo[0].push_back(b0);
    repeat (50) step();
    checks++; if (rd_cycles[0] != 0 || busy !== 1'b1 || done_q.size() != 0) begin errors++;
      $display("FAIL slow_wait got=%0d/%b exp=0/1", rd_cycles[0], busy); end
    fifo[0].push_back(b1);
    run_until_quiet(50, ok);
    checks++; if (!ok || rd_cycles[0] != 2) begin errors++; $display("FAIL slow_rdreq got=%0d exp=2", rd_cycles[0]); end
    checks++; if (done_q.size() != 1 || done_q[0] != 0 || drd_q[0] !== {b0, b1}) begin errors++;
      $display("FAIL slow_rdata got=%h exp=%h", done_q.size() > 0 ? drd_q[0] : 16'hxxxx, {b0, b1}); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs(); auto_resp = 0;
    wd[0] = W'($urandom); req_bus = 3'b001;
    ok = 0;
    for (int i = 0; i < 10; i++) begin step(); if (ack_q.size() > 0) begin ok = 1; break; end end
    checks++; if (!ok) begin errors++; $display("FAIL mid_ack got=none exp=ack"); end
    step();
    checks++; if (m_wrreq_bus !== 3'b001 || m_din !== wd[0][W-1 -: 8]) begin errors++;
      $display("FAIL mid_byte0 got=%b/%h exp=001/%h", m_wrreq_bus, m_din, wd[0][W-1 -: 8]); end
    rst = 1; req_bus = '0;
    step();
    checks++; if ({busy, ack_bus, done_bus, m_wrreq_bus, s_rdreq_bus, rdata, err, m_din} !== '0) begin errors++;
      $display("FAIL mid_reset got=%h exp=0", {busy, ack_bus, done_bus, m_wrreq_bus, s_rdreq_bus, rdata, err, m_din}); end
    repeat (3) step();
    rst = 0;
    repeat (5) step();
    checks++; if (done_q.size() != 0) begin errors++; $display("FAIL mid_no_done got=%0d exp=0", done_q.size()); end
    clear_logs(); auto_resp = 1;
    wd[0] = W'($urandom); resp[0] = W'($urandom); req_bus = 3'b001;
    run_until_quiet(60, ok);
    checks++; if (!ok || ack_q.size() != 1 || done_q.size() != 1) begin errors++;
      $display("FAIL mid_after got=%0d/%0d exp=1/1", ack_q.size(), done_q.size()); end
    checks++; if (done_q.size() != 1 || done_q[0] != 0 || drd_q[0] !== resp[0] || wr_b.size() != B || wr_b[0] !== wd[0][W-1 -: 8]) begin errors++;
      $display("FAIL mid_after_data got=%h exp=%h", done_q.size() > 0 ? drd_q[0] : 16'hxxxx, resp[0]); end
  endtask

  task automatic test_pulse_busy();
    bit ok;
    clear_logs(); auto_resp = 1;
    wd[0] = W'($urandom); resp[0] = W'($urandom); req_bus = 3'b001;
    ok = 0;
    for (int i = 0; i < 10; i++) begin step(); if (ack_q.size() > 0) begin ok = 1; break; end end
    step();
    req_bus = req_bus | 3'b100;
    step();
    req_bus = req_bus & 3'b011;
    run_until_quiet(60, ok);
    repeat (10) step();
    checks++; if (!ok || ack_q.size() != 1 || ack_q[0] != 0) begin errors++;
      $display("FAIL pulse_acks got=%0d exp=1", ack_q.size()); end
    checks++; if (done_q.size() != 1 || drd_q[0] !== resp[0] || busy !== 1'b0) begin errors++;
      $display("FAIL pulse_idle got=%0d/%b exp=1/0", done_q.size(), busy); end
  endtask

`ifdef SPI_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int c0;
    clear_logs(); auto_resp = 0;
    wd[1] = W'($urandom); req_bus = 3'b010;
    c0 = 0;
    for (int i = 0; i < 20; i++) begin step(); if (wr_s.size() == B) begin c0 = cyc; break; end end
    fifo[1].push_back(8'($urandom));
    ok = 0;
    for (int i = 0; i < TO + 40; i++) begin step(); if (done_q.size() > 0) begin ok = 1; break; end end
    checks++; if (!ok || dcyc_q[0] != c0 + TO + 3) begin errors++;
      $display("FAIL to_cycle got=%0d exp=%0d", ok ? dcyc_q[0] - c0 : -1, TO + 3); end
    checks++; if (!ok || drd_q[0] !== '0 || derr_q[0] !== 1'b1 || done_q[0] != 1) begin errors++;
      $display("FAIL to_result got=%h/%b exp=0/1", ok ? drd_q[0] : 16'hxxxx, ok ? derr_q[0] : 1'bx); end
    checks++; if (rd_cycles[1] != 1 || fifo[1].size() != 0) begin errors++;
      $display("FAIL to_flush got=%0d/%0d exp=1/0", rd_cycles[1], fifo[1].size()); end
    repeat (2) step();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin wd[i] = '0; resp[i] = '0; wr_cnt[i] = 0; rd_cycles[i] = 0; end
    test_reset();
    test_round_robin();
    test_single();
    test_slow_len();
    test_reset_mid();
    test_pulse_busy();
`ifdef SPI_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
